result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Back end of the per-warp dispatch/completion loop.
- Collects finished results from NumEus execution units and arbitrates them round-robin into the single register-file write port.
- After each accepted register write, returns exactly one completion (eu_valid_o/eu_tag_o) to multi-warp dispatch, which frees the instruction tag.
- Sits between the execution units and the register file / dispatcher.

Parameters:
- NumEus, 2, number of execution-unit result inputs (>=1)
- NumTags, 8, inflight instructions per warp
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp
- RegIdxWidth, 6, register index width
- RegWidth, 32, bits per thread register
- TagWidth (dependent), $clog2(NumTags)
- WidWidth (dependent), NumWarps>1 ? $clog2(NumWarps) : 1
- IidWidth (dependent), TagWidth+WidWidth; iid layout is {tag, wid}, with wid in bits [WidWidth-1:0]

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- eu_valid_i  in  NumEus  per-EU result valid
- eu_ready_o  out  NumEus  per-EU result accepted (grant)
- eu_iid_i  in  NumEus*IidWidth  instruction id of each result
- eu_dst_i  in  NumEus*RegIdxWidth  destination register
- eu_act_mask_i  in  NumEus*WarpWidth  threads to write
- eu_data_i  in  NumEus*WarpWidth*RegWidth  result data
- rf_wr_valid_o  out  1  register write request
- rf_wr_ready_i  in  1  register file accepts write
- rf_wr_wid_o  out  WidWidth  warp of write
- rf_wr_dst_o  out  RegIdxWidth  register index
- rf_wr_mask_o  out  WarpWidth  per-thread write enable
- rf_wr_data_o  out  WarpWidth*RegWidth  write data
- eu_valid_o  out  1  completion pulse to dispatcher
- eu_tag_o  out  IidWidth  completed iid

Behaviour:
- Reset (synchronous, rst_ni=0 at posedge):
  - output stage invalid; all rf_wr_* outputs 0.
  - eu_valid_o=0, eu_tag_o=0; RR pointer=0.
  - An entry held in the output stage at reset is dropped and produces no completion.
- Output stage: one register (valid, iid, dst, mask, data).
  - load_en = !out_valid_q || rf_wr_ready_i.
  - rf_wr_valid_o = out_valid_q.
  - rf_wr_wid_o = iid[WidWidth-1:0]; other rf_wr_* fields driven straight from the register.
  - While valid && !ready, all rf_wr_* hold stable; valid is never withdrawn.
- Arbitration:
  - Combinational; grant is at most one-hot.
  - Searches eu_valid_i starting at the RR pointer, ascending with wrap from NumEus-1 to 0.
  - eu_ready_o[i] = grant[i] && load_en; eu_ready_o never asserted for an input with eu_valid_i=0.
  - On EU handshake i: stage loads input i; pointer <= (i+1) mod NumEus.
  - Without a handshake the pointer holds. For NumEus=1 the pointer is constant 0.
- Throughput and latency:
  - Full throughput: one result per cycle with rf_wr_ready_i=1.
  - EU handshake to rf_wr_valid_o: 1 cycle.
  - Same-cycle drain and refill is allowed: rf handshake and EU handshake together keep valid=1 with new contents.
- Completion:
  - On rf handshake (rf_wr_valid_o && rf_wr_ready_i) at cycle N: eu_valid_o=1 and eu_tag_o=written iid in cycle N+1, for one cycle.
  - Otherwise eu_valid_o=0 and eu_tag_o holds its last value.
  - Exactly one completion per accepted result, in register-write order.
- An all-zero act mask is still written (mask 0) and still completed.
- No internal FIFO: backpressure propagates directly to the EUs through eu_ready_o.

Optional Feature:
- Macro: BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN.
- Defined:
  - eu_valid_o = rf_wr_valid_o && rf_wr_ready_i, combinational, same cycle as the write handshake.
  - eu_tag_o = output-stage iid.
  - Completion register removed; eu_tag_o undefined-but-stable when eu_valid_o=0 (drive the stage iid).
- Undefined: registered completion one cycle after the write handshake, as described under Behaviour.

Test Plan:
- Single result (NumEus=2, rf_wr_ready_i=1): EU0 iid=0x1A, dst=5, mask=0xFFFFFFFF at cycle 0 -> rf_wr_valid_o=1 cycle 1 with wid=2, dst=5; eu_valid_o=1, eu_tag_o=0x1A cycle 2; no other pulses.
- Round-robin fairness: both EUs valid for 6 cycles from reset -> grant order EU0, EU1, EU0, EU1, EU0, EU1; 6 writes and 6 completions in that order.
- Backpressure: stage holds iid=0x05 with rf_wr_ready_i=0 for 3 cycles -> rf_wr_* stable, eu_ready_o=0, no completion; ready rises -> completion 0x05 the next cycle, then the pending EU is accepted.
- Back-to-back streaming: EU1 valid for 4 consecutive cycles, iids 0x08..0x0B, ready=1 -> writes on cycles 1-4 with no bubble; completions on cycles 2-5.
- Reset mid-operation: stage valid with iid=0x11 while rf_wr_ready_i=0, then rst_ni=0 for 1 cycle -> rf_wr_valid_o=0, eu_valid_o=0, pointer 0, no completion for 0x11 ever emitted.
- Bypass build: same stimulus as the single-result test -> eu_valid_o=1 with eu_tag_o=0x1A in cycle 1, coincident with the write.

Source files
------------

// File: rtl/result_collector.sv
// Round-robin result collector: arbitrates EU results into one register-file write port
// and returns one completion per accepted write. Option: BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN.
module result_collector #(
   parameter  int NumEus      = 2,
   parameter  int NumTags     = 8,
   parameter  int NumWarps    = 8,
   parameter  int WarpWidth   = 32,
   parameter  int RegIdxWidth = 6,
   parameter  int RegWidth    = 32,
   localparam int TagWidth    = $clog2(NumTags),
   localparam int WidWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1,
   localparam int IidWidth    = TagWidth + WidWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumEus-1:0]                   eu_valid_i,
   output logic [NumEus-1:0]                   eu_ready_o,
   input  logic [NumEus*IidWidth-1:0]          eu_iid_i,
   input  logic [NumEus*RegIdxWidth-1:0]       eu_dst_i,
   input  logic [NumEus*WarpWidth-1:0]         eu_act_mask_i,
   input  logic [NumEus*WarpWidth*RegWidth-1:0] eu_data_i,
   output logic                                rf_wr_valid_o,
   input  logic                                rf_wr_ready_i,
   output logic [WidWidth-1:0]                 rf_wr_wid_o,
   output logic [RegIdxWidth-1:0]              rf_wr_dst_o,
   output logic [WarpWidth-1:0]                rf_wr_mask_o,
   output logic [WarpWidth*RegWidth-1:0]       rf_wr_data_o,
   output logic                                eu_valid_o,
   output logic [IidWidth-1:0]                 eu_tag_o
);

   localparam int PtrW  = (NumEus > 1) ? $clog2(NumEus) : 1;
   localparam int DataW = WarpWidth * RegWidth;

   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic                   out_valid_q, out_valid_d;
   logic [IidWidth-1:0]    out_iid_q, out_iid_d;
   logic [RegIdxWidth-1:0] out_dst_q, out_dst_d;
   logic [WarpWidth-1:0]   out_mask_q, out_mask_d;
   logic [DataW-1:0]       out_data_q, out_data_d;

   logic                   found;
   logic [PtrW-1:0]        gnt_idx;
   logic [NumEus-1:0]      grant;
   logic                   load_en;
   logic                   eu_hs;
   logic                   rf_hs;

   assign load_en = !out_valid_q || rf_wr_ready_i;
   assign rf_hs   = out_valid_q && rf_wr_ready_i;
   assign eu_hs   = found && load_en;

   // Rotating priority search starting at the pointer, wrapping past the last EU.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NumEus; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NumEus;
         if (!found && eu_valid_i[idx]) begin
            found   = 1'b1;
            gnt_idx = PtrW'(idx);
         end
      end
      for (int i = 0; i < NumEus; i++) begin
         grant[i] = found && (int'(gnt_idx) == i);
      end
   end

   assign eu_ready_o = grant & {NumEus{load_en}};

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_iid_d   = out_iid_q;
      out_dst_d   = out_dst_q;
      out_mask_d  = out_mask_q;
      out_data_d  = out_data_q;
      if (load_en) begin
         out_valid_d = found;
      end
      if (eu_hs) begin
         ptr_d      = PtrW'((int'(gnt_idx) + 1) % NumEus);
         out_iid_d  = eu_iid_i[int'(gnt_idx)*IidWidth +: IidWidth];
         out_dst_d  = eu_dst_i[int'(gnt_idx)*RegIdxWidth +: RegIdxWidth];
         out_mask_d = eu_act_mask_i[int'(gnt_idx)*WarpWidth +: WarpWidth];
         out_data_d = eu_data_i[int'(gnt_idx)*DataW +: DataW];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_iid_q   <= '0;
         out_dst_q   <= '0;
         out_mask_q  <= '0;
         out_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_iid_q   <= out_iid_d;
         out_dst_q   <= out_dst_d;
         out_mask_q  <= out_mask_d;
         out_data_q  <= out_data_d;
      end
   end

   assign rf_wr_valid_o = out_valid_q;
   assign rf_wr_wid_o   = out_iid_q[WidWidth-1:0];
   assign rf_wr_dst_o   = out_dst_q;
   assign rf_wr_mask_o  = out_mask_q;
   assign rf_wr_data_o  = out_data_q;

`ifdef BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN
   assign eu_valid_o = rf_hs;
   assign eu_tag_o   = out_iid_q;
`else
   // Completion is a one-cycle pulse after the write; the tag keeps its last value.
   logic                cmp_valid_q, cmp_valid_d;
   logic [IidWidth-1:0] cmp_tag_q, cmp_tag_d;

   always_comb begin
      cmp_valid_d = rf_hs;
      cmp_tag_d   = rf_hs ? out_iid_q : cmp_tag_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cmp_valid_q <= 1'b0;
         cmp_tag_q   <= '0;
      end else begin
         cmp_valid_q <= cmp_valid_d;
         cmp_tag_q   <= cmp_tag_d;
      end
   end

   assign eu_valid_o = cmp_valid_q;
   assign eu_tag_o   = cmp_tag_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: randomized EU traffic against a queue-based reference.
module tb_result_collector;

   localparam int N   = 2;
   localparam int IW  = 6;
   localparam int WW  = 3;
   localparam int RW  = 6;
   localparam int MW  = 32;
   localparam int DW  = 32 * 32;

   typedef struct {
      logic [IW-1:0] iid;
      logic [RW-1:0] dst;
      logic [MW-1:0] mask;
      logic [DW-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      eu_valid_i;
   logic [N-1:0]      eu_ready_o;
   logic [N*IW-1:0]   eu_iid_i;
   logic [N*RW-1:0]   eu_dst_i;
   logic [N*MW-1:0]   eu_act_mask_i;
   logic [N*DW-1:0]   eu_data_i;
   logic              rf_wr_valid_o;
   logic              rf_wr_ready_i;
   logic [WW-1:0]     rf_wr_wid_o;
   logic [RW-1:0]     rf_wr_dst_o;
   logic [MW-1:0]     rf_wr_mask_o;
   logic [DW-1:0]     rf_wr_data_o;
   logic              eu_valid_o;
   logic [IW-1:0]     eu_tag_o;

   result_collector dut (
      .clk_i(clk), .rst_ni(rst_n),
      .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o),
      .eu_iid_i(eu_iid_i), .eu_dst_i(eu_dst_i),
      .eu_act_mask_i(eu_act_mask_i), .eu_data_i(eu_data_i),
      .rf_wr_valid_o(rf_wr_valid_o), .rf_wr_ready_i(rf_wr_ready_i),
      .rf_wr_wid_o(rf_wr_wid_o), .rf_wr_dst_o(rf_wr_dst_o),
      .rf_wr_mask_o(rf_wr_mask_o), .rf_wr_data_o(rf_wr_data_o),
      .eu_valid_o(eu_valid_o), .eu_tag_o(eu_tag_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: pending item per EU, expected writes, stage occupancy, last EU served.
   wr_t  cur [N];
   bit   cur_vld [N];
   wr_t  wq [$];
   bit   m_valid;
   int   last_srv;
   bit   stall_prev;
   logic [RW+MW+WW-1:0] snap;
   logic [DW-1:0]       snap_data;

   bit            pend;
   logic [IW-1:0] pend_iid;
   logic [IW-1:0] last_tag;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic set_item(input int e, input logic [IW-1:0] iid, input logic [RW-1:0] dst,
                           input logic [MW-1:0] mask);
      cur[e].iid  = iid;
      cur[e].dst  = dst;
      cur[e].mask = mask;
      for (int w = 0; w < 32; w++) cur[e].data[w*32 +: 32] = $urandom;
      cur_vld[e] = 1'b1;
   endtask

   task automatic rand_item(input int e);
      logic [MW-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
      set_item(e, IW'($urandom), RW'($urandom), m);
   endtask

   task automatic step(input int arr_pct, input int rdy_pct);
      bit            load_en;
      int            w;
      logic [N-1:0]  exp_rdy;
      @(negedge clk);
      for (int e = 0; e < N; e++)
         if (!cur_vld[e] && $urandom_range(0, 99) < arr_pct) rand_item(e);
      for (int e = 0; e < N; e++) begin
         eu_valid_i[e]              = cur_vld[e];
         eu_iid_i[e*IW +: IW]       = cur[e].iid;
         eu_dst_i[e*RW +: RW]       = cur[e].dst;
         eu_act_mask_i[e*MW +: MW]  = cur[e].mask;
         eu_data_i[e*DW +: DW]      = cur[e].data;
      end
      rf_wr_ready_i = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (stall_prev) begin
         chk("stall_hold", 64'({rf_wr_dst_o, rf_wr_mask_o, rf_wr_wid_o}), 64'(snap));
         chk("stall_data", 64'(rf_wr_data_o == snap_data), 64'd1);
      end
      load_en = !m_valid || rf_wr_ready_i;
      w = -1;
      for (int k = 1; k <= N; k++)
         if (w < 0 && cur_vld[(last_srv + k) % N]) w = (last_srv + k) % N;
      exp_rdy = '0;
      if (load_en && w >= 0) exp_rdy[w] = 1'b1;
      chk("eu_ready", 64'(eu_ready_o), 64'(exp_rdy));
      chk("wr_valid", 64'(rf_wr_valid_o), 64'(m_valid));
      stall_prev = m_valid && !rf_wr_ready_i;
      snap       = {rf_wr_dst_o, rf_wr_mask_o, rf_wr_wid_o};
      snap_data  = rf_wr_data_o;
      if (m_valid && rf_wr_ready_i) m_valid = 1'b0;
      if (load_en && w >= 0) begin
         wq.push_back(cur[w]);
         m_valid    = 1'b1;
         last_srv   = w;
         cur_vld[w] = 1'b0;
      end
   endtask

   task automatic clear_model();
      wq.delete();
      m_valid    = 1'b0;
      last_srv   = N - 1;
      stall_prev = 1'b0;
      for (int e = 0; e < N; e++) cur_vld[e] = 1'b0;
   endtask

   // Monitor: every register write pops the next expected result; completions are checked for timing.
   always @(posedge clk) begin
      if (!rst_n) begin
         pend     = 1'b0;
         last_tag = '0;
      end else begin
`ifndef BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN
         chk("cmp_valid", 64'(eu_valid_o), 64'(pend));
         chk("cmp_tag", 64'(eu_tag_o), 64'(pend ? pend_iid : last_tag));
         pend = 1'b0;
`endif
         if (rf_wr_valid_o && rf_wr_ready_i) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 64'd1, 64'd0);
            end else begin
               wr_t x;
               x = wq.pop_front();
               chk("wr_wid", 64'(rf_wr_wid_o), 64'(x.iid[WW-1:0]));
               chk("wr_dst", 64'(rf_wr_dst_o), 64'(x.dst));
               chk("wr_mask", 64'(rf_wr_mask_o), 64'(x.mask));
               chk("wr_data", 64'(rf_wr_data_o == x.data), 64'd1);
`ifdef BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN
               chk("byp_valid", 64'(eu_valid_o), 64'd1);
               chk("byp_tag", 64'(eu_tag_o), 64'(x.iid));
`else
               pend     = 1'b1;
               pend_iid = x.iid;
               last_tag = x.iid;
`endif
            end
         end
`ifdef BGPU_RESULT_COLLECTOR_COMPLETION_BYPASS_EN
         else chk("byp_idle", 64'(eu_valid_o), 64'd0);
`endif
      end
   end

   initial begin
      rst_n = 1'b0;
      eu_valid_i = '0; eu_iid_i = '0; eu_dst_i = '0; eu_act_mask_i = '0; eu_data_i = '0;
      rf_wr_ready_i = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      chk("rst_wr_valid", 64'(rf_wr_valid_o), 64'd0);
      chk("rst_wr_fields", 64'({rf_wr_wid_o, rf_wr_dst_o, rf_wr_mask_o}), 64'd0);
      chk("rst_wr_data", 64'(rf_wr_data_o == '0), 64'd1);
      chk("rst_cmp", 64'({eu_valid_o, eu_tag_o}), 64'd0);
      rst_n = 1'b1;

      // Both EUs continuously valid: alternating grants from EU0.
      for (int c = 0; c < 6; c++) begin
         for (int e = 0; e < N; e++) if (!cur_vld[e]) rand_item(e);
         step(0, 100);
      end
      repeat (3) step(0, 100);

      // Single result with full mask.
      set_item(0, 6'h1A, 6'd5, 32'hFFFF_FFFF);
      repeat (4) step(0, 100);

      // Backpressure with a pending EU, then drain-and-refill in one cycle.
      set_item(0, 6'h05, 6'd9, 32'h0000_00F0);
      step(0, 100);
      set_item(1, 6'h2C, 6'd3, 32'h0);
      repeat (3) step(0, 0);
      repeat (4) step(0, 100);

      // Back-to-back streaming on EU1.
      for (int c = 0; c < 4; c++) begin
         set_item(1, 6'(8 + c), 6'(c), 32'h1234_5678);
         step(0, 100);
      end
      repeat (3) step(0, 100);

      // Reset while a stalled result sits in the stage: it must vanish without completion.
      set_item(0, 6'h11, 6'd7, 32'hA5A5_A5A5);
      repeat (3) step(0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      eu_valid_i = '0;
      clear_model();
      @(negedge clk);
      chk("midrst_wr_valid", 64'(rf_wr_valid_o), 64'd0);
      chk("midrst_cmp", 64'(eu_valid_o), 64'd0);
      rst_n = 1'b1;
      for (int e = 0; e < N; e++) rand_item(e);
      repeat (4) step(0, 100);

      // Random traffic with random backpressure, then drain.
      repeat (600) step(45, 70);
      repeat (12) step(0, 100);
      chk("queue_empty", 64'(wq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
